// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch stage: owns the PC, issues single-cycle-latency imem reads,
// and buffers {instruction, NPC} pairs in a small FIFO toward decode.
module mips32_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              halt,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_ir,
   output logic [31:0]       id_npc,
   output logic [CW-1:0]     queue_count,
   output logic [31:0]       pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned SW = CW + 1;

   logic [31:0]   r_pc;
   logic [31:0]   r_tag;
   logic          r_inflight;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [31:0]   r_fifo_ir  [DEPTH];
   logic [31:0]   r_fifo_npc [DEPTH];

   logic [SW-1:0] w_occ;
   logic          w_issue;
   logic          w_push;
   logic          w_pop;
   logic [PW-1:0] w_wr_next;
   logic [PW-1:0] w_rd_next;

   // Issue only when a slot is guaranteed for the response, so the FIFO never overflows
   assign w_occ     = SW'(r_count) + SW'(r_inflight);
   assign w_issue   = reset_n & ~halt & ~redirect_valid & (w_occ < SW'(DEPTH));
   assign w_push    = r_inflight & ~redirect_valid;
   assign w_pop     = (r_count != '0) & id_ready & ~redirect_valid;
   assign w_wr_next = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
   assign w_rd_next = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

   assign imem_req    = w_issue;
   assign imem_addr   = r_pc[ADDR_W-1:0];
   assign id_valid    = (r_count != '0);
   assign id_ir       = r_fifo_ir[r_rd_ptr];
   assign id_npc      = r_fifo_npc[r_rd_ptr];
   assign queue_count = r_count;
   assign pc          = r_pc;

   // PC, in-flight tracking and FIFO state; a redirect flushes everything
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc       <= RESET_PC;
         r_tag      <= '0;
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_fifo_ir[i]  <= '0;
            r_fifo_npc[i] <= '0;
         end
      end else if (redirect_valid) begin
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         if (w_push) begin
            r_fifo_ir[r_wr_ptr]  <= imem_rdata;
            r_fifo_npc[r_wr_ptr] <= r_tag + 32'd1;
            r_wr_ptr             <= w_wr_next;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc  <= r_pc + 32'd1;
            r_tag <= r_pc;
         end
      end
   end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mips32_fetch_queue;

   localparam int DEPTH = 4;

   logic        clock;
   logic        reset_n;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_ir;
   logic [31:0] id_npc;
   logic [2:0]  queue_count;
   logic [31:0] pc;

   mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(10), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir),
      .id_npc(id_npc), .queue_count(queue_count), .pc(pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] mem [1024];
   always @(posedge clock) if (imem_req) imem_rdata <= mem[imem_addr];

   int total = 0;
   int bad   = 0;

   // Reference model: a plain queue of delivered words plus the fetch pointer
   typedef struct { logic [31:0] ir; logic [31:0] npc; } ent_t;
   ent_t        q[$];
   logic [31:0] m_pc;
   logic [31:0] m_tag;
   bit          m_infl;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_req();
      return !halt && !redirect_valid && (q.size() + int'(m_infl) < DEPTH);
   endfunction

   task automatic drive(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy);
      halt = h; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
      #2;
   endtask

   task automatic check_model();
      chk("req",   32'(imem_req),    32'(m_req()));
      chk("addr",  32'(imem_addr),   32'(m_pc[9:0]));
      chk("valid", 32'(id_valid),    32'(q.size() != 0));
      chk("count", 32'(queue_count), 32'(q.size()));
      chk("pc",    pc,               m_pc);
      if (q.size() != 0) begin
         chk("ir",  id_ir,  q[0].ir);
         chk("npc", id_npc, q[0].npc);
      end
      chk("occ_inv", 32'((int'(dut.r_count) + int'(dut.r_inflight)) <= DEPTH), 32'd1);
   endtask

   task automatic advance();
      bit req;
      bit push;
      ent_t e;
      @(posedge clock);
      req  = m_req();
      push = m_infl;
      if (redirect_valid) begin
         q.delete();
         m_infl = 0;
         m_pc   = redirect_pc;
      end else begin
         if (q.size() != 0 && id_ready) void'(q.pop_front());
         if (push) begin
            e.ir  = mem[m_tag[9:0]];
            e.npc = m_tag + 32'd1;
            q.push_back(e);
         end
         if (req) begin
            m_tag = m_pc;
            m_pc  = m_pc + 32'd1;
         end
         m_infl = req;
      end
      @(negedge clock);
      #1;
   endtask

   task automatic step(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy);
      drive(h, rv, rpc, rdy);
      check_model();
      advance();
   endtask

   task automatic do_reset();
      halt = 0; redirect_valid = 0; redirect_pc = 0;
      reset_n = 0;
      #1;
      chk("rst_req",   32'(imem_req),    0);
      chk("rst_valid", 32'(id_valid),    0);
      chk("rst_ir",    id_ir,            0);
      chk("rst_npc",   id_npc,           0);
      chk("rst_count", 32'(queue_count), 0);
      chk("rst_pc",    pc,               0);
      q.delete(); m_pc = 0; m_tag = 0; m_infl = 0;
      repeat (2) @(negedge clock);
      #1;
      reset_n = 1;
   endtask

   task automatic wait_valid(input logic rdy, input int max);
      bit got = 0;
      for (int n = 0; n < max; n++) begin
         drive(0, 0, 0, rdy);
         if (id_valid) begin
            got = 1;
            break;
         end
         check_model();
         advance();
      end
      chk("wait_valid", 32'(got), 1);
   endtask

   typedef struct {
      logic        rdy;
      logic        req;
      logic [9:0]  addr;
      logic        valid;
      logic [31:0] ir;
      logic [2:0]  cnt;
      logic [31:0] pc;
   } vec_t;

   initial begin
      vec_t tbl[11];
      int   thr;
      reset_n = 0; halt = 0; redirect_valid = 0; redirect_pc = 0; id_ready = 0;
      for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + 32'(k);

      // Cycle-by-cycle from reset release: fill with id_ready low, then drain
      tbl[0]  = '{1, 1, 0, 0, 32'h0,         0, 0};
      tbl[1]  = '{1, 1, 1, 0, 32'h0,         0, 1};
      tbl[2]  = '{0, 1, 2, 1, 32'h1000_0000, 1, 2};
      tbl[3]  = '{0, 1, 3, 1, 32'h1000_0000, 2, 3};
      tbl[4]  = '{0, 0, 4, 1, 32'h1000_0000, 3, 4};
      tbl[5]  = '{0, 0, 4, 1, 32'h1000_0000, 4, 4};
      tbl[6]  = '{0, 0, 4, 1, 32'h1000_0000, 4, 4};
      tbl[7]  = '{1, 0, 4, 1, 32'h1000_0000, 4, 4};
      tbl[8]  = '{1, 1, 4, 1, 32'h1000_0001, 3, 4};
      tbl[9]  = '{1, 1, 5, 1, 32'h1000_0002, 2, 5};
      tbl[10] = '{1, 1, 6, 1, 32'h1000_0003, 2, 6};

      @(negedge clock);
      #1;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(0, 0, 0, tbl[i].rdy);
         check_model();
         chk($sformatf("tbl%0d_req", i),   32'(imem_req),    32'(tbl[i].req));
         chk($sformatf("tbl%0d_addr", i),  32'(imem_addr),   32'(tbl[i].addr));
         chk($sformatf("tbl%0d_valid", i), 32'(id_valid),    32'(tbl[i].valid));
         chk($sformatf("tbl%0d_ir", i),    id_ir,            tbl[i].ir);
         chk($sformatf("tbl%0d_cnt", i),   32'(queue_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_pc", i),    pc,               tbl[i].pc);
         advance();
      end
      repeat (10) step(0, 0, 0, 1);

      // Redirect with three queued and one in flight
      do_reset();
      repeat (4) step(0, 0, 0, 0);
      drive(0, 1, 32'h40, 0);
      chk("t3_cnt_pre", 32'(queue_count), 3);
      check_model(); advance();
      drive(0, 0, 0, 1);
      chk("t3_cnt", 32'(queue_count), 0);
      chk("t3_valid", 32'(id_valid), 0);
      chk("t3_addr", 32'(imem_addr), 32'h40);
      chk("t3_req", 32'(imem_req), 1);
      check_model(); advance();
      wait_valid(1, 10);
      chk("t3_ir", id_ir, 32'h1000_0040);
      chk("t3_npc", id_npc, 32'h41);
      check_model(); advance();

      // Redirect coinciding with a pop
      repeat (2) step(0, 0, 0, 1);
      drive(0, 1, 32'h80, 1);
      chk("t4_valid_pre", 32'(id_valid), 1);
      check_model(); advance();
      drive(0, 0, 0, 1);
      chk("t4_cnt", 32'(queue_count), 0);
      chk("t4_valid", 32'(id_valid), 0);
      check_model(); advance();
      wait_valid(1, 10);
      chk("t4_ir", id_ir, 32'h1000_0080);
      chk("t4_npc", id_npc, 32'h81);
      check_model(); advance();

      // Halt while one request is in flight and two entries are queued
      do_reset();
      repeat (3) step(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      chk("t5_req", 32'(imem_req), 0);
      chk("t5_cnt2", 32'(queue_count), 2);
      check_model(); advance();
      drive(1, 0, 0, 0);
      chk("t5_cnt3", 32'(queue_count), 3);
      check_model(); advance();
      repeat (5) step(1, 0, 0, 1);
      drive(1, 0, 0, 1);
      chk("t5_valid", 32'(id_valid), 0);
      chk("t5_pc", pc, 3);
      check_model(); advance();
      drive(0, 0, 0, 1);
      chk("t5_resume_req", 32'(imem_req), 1);
      chk("t5_resume_addr", 32'(imem_addr), 3);
      check_model(); advance();
      wait_valid(1, 10);
      chk("t5_ir", id_ir, 32'h1000_0003);
      chk("t5_npc", id_npc, 32'h4);
      check_model(); advance();

      // Reset mid-stream discards queued words fetched from 0x100
      step(0, 1, 32'h100, 0);
      repeat (4) step(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("t6_cnt_pre", 32'(queue_count), 3);
      do_reset();
      wait_valid(1, 10);
      chk("t6_ir", id_ir, 32'h1000_0000);
      chk("t6_npc", id_npc, 32'h1);
      check_model(); advance();

      // PC wrap from 0xFFFFFFFF to 0
      step(0, 1, 32'hFFFF_FFFF, 1);
      wait_valid(1, 10);
      chk("wrap_ir", id_ir, 32'h1000_03FF);
      chk("wrap_npc", id_npc, 32'h0);
      check_model(); advance();
      drive(0, 0, 0, 1);
      chk("wrap_ir2", id_ir, 32'h1000_0000);
      chk("wrap_npc2", id_npc, 32'h1);
      check_model(); advance();

      // Randomized traffic with varying back-pressure
      for (int blk = 0; blk < 6; blk++) begin
         thr = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 2 : 3);
         for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 999) < 4) begin
               do_reset();
            end else begin
               step(logic'($urandom_range(0, 7) == 0),
                    logic'($urandom_range(0, 24) == 0),
                    $urandom,
                    logic'($urandom_range(0, 3) < thr));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips32_fetch_queue.md
Name: mips32_fetch_queue

Overview:
- Instruction prefetch stage that sits directly upstream of the MIPS32 pipeline's ID stage.
- Owns the PC and issues word reads to a synchronous instruction memory with one-cycle read latency.
- Buffers fetched words with their NPC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch redirects from EX (flushes the queue and drops the in-flight read) and a halt request from WB.

Parameters:
DEPTH, 4, FIFO entries; legal range 3..16 (3 is the minimum for 1 instr/cycle throughput)
ADDR_W, 10, instruction memory word-address width (1024 words)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  read request this cycle; combinational, forced 0 while reset_n low
imem_addr  output  ADDR_W  word address = pc[ADDR_W-1:0]
imem_rdata  input  32  read data, valid the cycle after imem_req was high
redirect_valid  input  1  taken-branch redirect from EX, single-cycle pulse
redirect_pc  input  32  branch target word address
halt  input  1  level; while high, no new fetches are issued
id_valid  output  1  head entry valid toward decode
id_ready  input  1  decode accepts the head this cycle
id_ir  output  32  head instruction word
id_npc  output  32  head instruction address + 1
queue_count  output  $clog2(DEPTH+1)  current occupancy
pc  output  32  next fetch address

Behaviour:
- Reset (asynchronous, reset_n low):
  - pc=RESET_PC; count=0; inflight=0; FIFO pointers=0; all FIFO entries=0.
  - Outputs: id_valid=0, id_ir=0, id_npc=0, imem_req=0, queue_count=0.
- Reset mid-operation discards all queued and in-flight words. No response is enqueued for a request issued in the cycle reset asserts.
- Issue rule: imem_req = reset_n & ~halt & ~redirect_valid & (count + inflight < DEPTH).
  - No pop credit is taken, so the FIFO can never overflow.
- On an issue cycle:
  - pc <= pc+1 (32-bit wrap from 0xFFFFFFFF to 0).
  - inflight <= 1; the issued pc is recorded as the request tag.
- Response cycle (inflight=1, no redirect): push {imem_rdata, tag+1} at the tail; inflight clears unless a new request issues.
- Latency:
  - Request in cycle N; data is pushed at the end of cycle N+1; id_valid is high in cycle N+2.
  - First id_valid after reset release is in cycle 2.
  - Sustained throughput is 1 instr/cycle with id_ready held high.
- Handshake:
  - id_valid = (count != 0).
  - Pop occurs when id_valid & id_ready.
  - id_ir and id_npc are driven from the head register and are held stable while id_valid=1 and id_ready=0.
- Simultaneous push and pop: count is unchanged and both pointers advance (wrap modulo DEPTH).
- Pop when empty has no effect.
- Redirect (redirect_valid=1), highest priority:
  - FIFO cleared (count=0, pointers reset), inflight cleared, and any response arriving that cycle is dropped.
  - A pop in the same cycle is ignored; the head is discarded.
  - pc <= redirect_pc.
  - No request is issued in the redirect cycle. The first fetch at redirect_pc issues the next cycle, so id_valid=0 for at least 2 cycles after redirect.
- Redirect while halt=1: the flush and pc update still occur; no fetch issues until halt drops.
- Halt:
  - Blocks new requests only.
  - An outstanding response is still pushed, and queued entries continue to drain to decode.
  - pc holds.
- queue_count = count, registered.
- Invariant: count + inflight <= DEPTH. The bench checks this with an assertion.

Test Plan:
1. Reset release with id_ready=1 and imem preloaded mem[k]=0x1000_0000+k -> id_valid rises in cycle 2; consecutive pops show id_ir=0x1000_0000, 0x1000_0001, ... with id_npc=1, 2, ...; no bubbles after the first.
2. id_ready=0 for 10 cycles -> queue_count saturates at DEPTH=4, imem_req low once full, pc=4. Then id_ready=1 -> four entries drain in order, and fetching resumes at address 4 with no loss or duplication.
3. redirect_valid with redirect_pc=0x40 while 3 entries are queued and 1 is in flight -> next cycle queue_count=0, id_valid=0, the stale response is not pushed, imem_addr=0x40; the first popped id_ir=mem[0x40] and id_npc=0x41.
4. redirect_valid and id_valid&id_ready in the same cycle -> no pop is reported downstream, the queue is cleared, and the next delivered word is from redirect_pc.
5. halt raised while inflight=1 and count=2 -> imem_req=0 from that cycle, the outstanding word is still pushed (count=3), all 3 drain, then id_valid=0 and pc is frozen. halt lowered -> fetch resumes at the frozen pc.
6. reset_n pulsed low mid-stream with count=3 -> all outputs are immediately 0; after release, fetch restarts at RESET_PC and the pre-reset words never appear on id_ir.
